isa_cycle_initiator: RTL and testbench
======================================

Name: isa_cycle_initiator

Overview:
- ISA bus initiator. It turns single-beat host requests into ISA I/O or memory cycles aimed at on-board ISA responders, including the CGA/MDA video adapters.
- Drives address, AEN, the four active-low strobes and write data, and honours target wait states via bus_rdy.
- Captures read data only when the target asserts bus_dir; otherwise returns floating-bus 0xFF.
- Sits between the CPU/BIU request path and the shared ISA signal bundle.

Parameters:
SETUP_CYCLES, 1, cycles address/AEN are stable before strobe assertion (>=1)
STROBE_CYCLES, 4, minimum strobe-low cycles (>=1)
RECOVERY_CYCLES, 2, idle cycles after strobe release before the next request is accepted (>=1)
RDY_TIMEOUT, 255, maximum WAIT cycles before abort (only used with ISA_INIT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  host request present
req_ready  out  1  initiator can accept a request
req_write  in  1  1=write, 0=read
req_io  in  1  1=I/O cycle, 0=memory cycle
req_addr  in  20  cycle address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read data, valid with rsp_valid
rsp_timeout  out  1  cycle aborted by timeout, valid with rsp_valid
bus_a  out  20  ISA address
bus_aen  out  1  address enable (1 = no initiator cycle)
bus_ior_l  out  1  I/O read strobe
bus_iow_l  out  1  I/O write strobe
bus_memr_l  out  1  memory read strobe
bus_memw_l  out  1  memory write strobe
bus_d  out  8  write data to targets
bus_d_oe  out  1  bus_d driven
bus_din  in  8  read data from targets
bus_dir  in  1  target driving read data
bus_rdy  in  1  target ready (0 = insert wait)

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - req_ready=0 during reset, then 1 from the first cycle after reset.
  - rsp_valid=0, rsp_rdata=0x00, rsp_timeout=0.
  - bus_a=0, bus_aen=1, all strobes=1, bus_d=0, bus_d_oe=0.
- States: IDLE, SETUP, STROBE, WAIT, RECOVER.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready (cycle T0). Latch write/io/addr/wdata.
  - Next state SETUP.
- SETUP:
  - Lasts SETUP_CYCLES.
  - bus_a = latched address; for I/O cycles, bits [19:16] are forced to 0.
  - bus_aen=0.
  - Writes: bus_d=wdata, bus_d_oe=1.
- STROBE:
  - Exactly one strobe is low, selected by io/write.
  - Held for STROBE_CYCLES.
  - On the last STROBE cycle, if the registered copy of bus_rdy is 1, finish. Otherwise go to WAIT.
- WAIT:
  - Strobe stays low until bus_rdy=1 is sampled.
  - Finish on the cycle after bus_rdy=1 is sampled.
- Finish:
  - Strobe goes high and the state becomes RECOVER.
  - rsp_valid pulses for exactly one cycle, the first RECOVER cycle.
  - Reads: rsp_rdata = bus_din when bus_dir was 1 on the final strobe-low cycle, else 0xFF.
  - Writes: rsp_rdata=0x00.
- RECOVER:
  - Lasts RECOVERY_CYCLES.
  - bus_a is held; bus_aen=1; bus_d_oe=0 from the second RECOVER cycle.
  - Then IDLE.
- Default latency (writes, no waits):
  - T0 accept, T1 SETUP, T2–T5 strobe low, T6 rsp_valid, T8 req_ready=1.
  - Each sampled bus_rdy=0 adds one cycle.
- Handshake rules:
  - req_ready=0 in every non-IDLE state.
  - Request fields are ignored while req_ready=0.
  - rsp_valid and req_ready are never high in the same cycle.
- Reset mid-operation: on the next edge all strobes go high, bus_aen=1, bus_d_oe=0. No rsp_valid is issued for the aborted cycle.
- Invariant: at most one strobe is low at any time. Strobes are never low while bus_aen=1.

Optional Feature:
- Macro: ISA_INIT_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter runs in WAIT.
  - After RDY_TIMEOUT WAIT cycles without bus_rdy, finish with rsp_timeout=1 and rsp_rdata=0xFF.
- Undefined:
  - WAIT is unbounded.
  - rsp_timeout is tied 0 and the counter is not built.

Test Plan:
1. I/O write addr 0x003D8, data 0x29, bus_rdy=1 -> bus_a=0x003D8 and bus_aen=0 from T1; bus_iow_l=0 T2–T5 with bus_d=0x29, bus_d_oe=1; rsp_valid at T6; req_ready=1 at T8.
2. I/O read 0x3DA, target bus_dir=1, bus_din=0xF9 -> bus_ior_l low 4 cycles; rsp_rdata=0xF9, rsp_timeout=0.
3. Memory read 0xB8000, bus_rdy=0 for 3 cycles from T4, bus_din=0x41 -> bus_memr_l extends 3 cycles; rsp_valid at T9 with 0x41.
4. Memory read 0xC0000, bus_dir=0 -> rsp_rdata=0xFF.
5. Reset asserted at T3 of a memory write -> next cycle bus_memw_l=1, bus_aen=1, bus_d_oe=0; no rsp_valid ever; req_ready=1 after reset drops.
6. ISA_INIT_TIMEOUT_EN defined, RDY_TIMEOUT=8, bus_rdy held 0 -> rsp_valid with rsp_timeout=1 and rsp_rdata=0xFF after 8 WAIT cycles; undefined build keeps strobe low indefinitely.

Source files
------------

// File: rtl/isa_cycle_initiator.sv
// ISA bus initiator: turns single-beat host requests into ISA I/O or memory cycles.
// Optional ready timeout in WAIT is built when ISA_INIT_TIMEOUT_EN is defined.
module isa_cycle_initiator #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 2,
    parameter int RDY_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_din,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] RECOVER_LAST = 16'(RECOVERY_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        io_q, io_d;
    logic        rdy_q;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic        bus_aen_q, bus_aen_d;
    logic [3:0]  strobe_l_q, strobe_l_d;  // {ior, iow, memr, memw}, active low
    logic [7:0]  bus_d_q, bus_d_d;
    logic        bus_d_oe_q, bus_d_oe_d;
    logic        finish_s;
    logic        abort_s;
`ifdef ISA_INIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(RDY_TIMEOUT - 1);
    logic [15:0] tcnt_q, tcnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`endif

    function automatic logic [3:0] strobe_sel(input logic io, input logic write);
        logic [3:0] sel;
        case ({io, write})
            2'b11:   sel = 4'b1011;
            2'b10:   sel = 4'b0111;
            2'b01:   sel = 4'b1110;
            default: sel = 4'b1101;
        endcase
        return sel;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        io_d        = io_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bus_a_d     = bus_a_q;
        bus_aen_d   = bus_aen_q;
        strobe_l_d  = strobe_l_q;
        bus_d_d     = bus_d_q;
        bus_d_oe_d  = bus_d_oe_q;
        finish_s    = 1'b0;
        abort_s     = 1'b0;
`ifdef ISA_INIT_TIMEOUT_EN
        tcnt_d        = tcnt_q;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = S_SETUP;
                    cnt_d       = 16'd0;
                    write_d     = req_write;
                    io_d        = req_io;
                    req_ready_d = 1'b0;
                    bus_a_d     = req_io ? {4'h0, req_addr[15:0]} : req_addr;
                    bus_aen_d   = 1'b0;
                    bus_d_oe_d  = req_write;
                    if (req_write) begin
                        bus_d_d = req_wdata;
                    end else begin
                        bus_d_d = bus_d_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d    = S_STROBE;
                    cnt_d      = 16'd0;
                    strobe_l_d = strobe_sel(io_q, write_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q != STROBE_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (rdy_q) begin
                    finish_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
`ifdef ISA_INIT_TIMEOUT_EN
                    tcnt_d = 16'd0;
`endif
                end
            end
            S_WAIT: begin
                if (rdy_q) begin
                    finish_s = 1'b1;
                end else begin
`ifdef ISA_INIT_TIMEOUT_EN
                    if (tcnt_q == TIMEOUT_LAST) begin
                        finish_s = 1'b1;
                        abort_s  = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_RECOVER: begin
                // Data drivers stay on through the first recovery cycle for write hold time.
                bus_d_oe_d = 1'b0;
                if (cnt_q == RECOVER_LAST) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                bus_aen_d   = 1'b1;
                strobe_l_d  = 4'b1111;
                bus_d_oe_d  = 1'b0;
            end
        endcase

        if (finish_s) begin
            state_d     = S_RECOVER;
            cnt_d       = 16'd0;
            strobe_l_d  = 4'b1111;
            bus_aen_d   = 1'b1;
            rsp_valid_d = 1'b1;
            if (abort_s || (!write_q && !bus_dir)) begin
                rsp_rdata_d = 8'hFF;
            end else if (write_q) begin
                rsp_rdata_d = 8'h00;
            end else begin
                rsp_rdata_d = bus_din;
            end
`ifdef ISA_INIT_TIMEOUT_EN
            rsp_timeout_d = abort_s;
`endif
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State, bus and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            rdy_q       <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            bus_a_q     <= 20'h00000;
            bus_aen_q   <= 1'b1;
            strobe_l_q  <= 4'b1111;
            bus_d_q     <= 8'h00;
            bus_d_oe_q  <= 1'b0;
`ifdef ISA_INIT_TIMEOUT_EN
            tcnt_q        <= 16'd0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            io_q        <= io_d;
            rdy_q       <= bus_rdy;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_a_q     <= bus_a_d;
            bus_aen_q   <= bus_aen_d;
            strobe_l_q  <= strobe_l_d;
            bus_d_q     <= bus_d_d;
            bus_d_oe_q  <= bus_d_oe_d;
`ifdef ISA_INIT_TIMEOUT_EN
            tcnt_q        <= tcnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign bus_a      = bus_a_q;
    assign bus_aen    = bus_aen_q;
    assign bus_ior_l  = strobe_l_q[3];
    assign bus_iow_l  = strobe_l_q[2];
    assign bus_memr_l = strobe_l_q[1];
    assign bus_memw_l = strobe_l_q[0];
    assign bus_d      = bus_d_q;
    assign bus_d_oe   = bus_d_oe_q;
`ifdef ISA_INIT_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_isa_cycle_initiator.sv
// Scoreboard bench for isa_cycle_initiator: cycle-by-cycle bus timing plus queued response data.
module tb_isa_cycle_initiator;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_write, req_io, bus_dir, bus_rdy;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata, bus_din;
    logic        req_ready, rsp_valid, rsp_timeout, bus_aen, bus_d_oe;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic [7:0]  rsp_rdata, bus_d;
    logic [19:0] bus_a;

    int vecs = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] want;

    always #5 clk = ~clk;

    isa_cycle_initiator #(.RDY_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_a(bus_a), .bus_aen(bus_aen), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_d(bus_d), .bus_d_oe(bus_d_oe),
        .bus_din(bus_din), .bus_dir(bus_dir), .bus_rdy(bus_rdy)
    );

    wire [7:0] obs = {bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_d_oe, rsp_valid, req_ready};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference control pattern for cycle t of a transfer whose last strobe-low cycle is se.
    function automatic logic [7:0] exp_ctl(int t, int se, logic wr, logic io);
        logic [3:0] sl;
        logic [7:0] v;
        sl = 4'b1111;
        if (t >= 2 && t <= se) begin
            case ({io, wr})
                2'b11:   sl = 4'b1011;
                2'b10:   sl = 4'b0111;
                2'b01:   sl = 4'b1110;
                default: sl = 4'b1101;
            endcase
        end
        v = {1'b1, sl, 3'b000};
        if (t <= se) begin
            v[7] = 1'b0;
            v[2] = wr;
        end else if (t == se + 1) begin
            v[2] = wr;
            v[1] = 1'b1;
        end else if (t >= se + 3) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    // Waits (bounded) for req_ready, then presents one request for the accept cycle T0.
    task automatic issue(input logic wr, input logic io, input logic [19:0] a, input logic [7:0] wd,
                         output int waited);
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vecs++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_io = io; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_write = ~wr; req_io = ~io;
        req_addr = 20'($urandom); req_wdata = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vecs++;
        if (obs !== 8'b1111_1000 || bus_a !== 20'h0 || bus_d !== 8'h00 ||
            rsp_rdata !== 8'h00 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vals: ctl=%b a=%h d=%h rd=%h to=%b required ctl=11111000 zeros",
                     obs, bus_a, bus_d, rsp_rdata, rsp_timeout);
        end
        reset = 1'b0;
        tick(); tick();
        vecs++;
        if (obs !== 8'b1111_1001) begin
            miscompares++;
            $display("FAIL reset_release: ctl=%b required 11111001", obs);
        end
    endtask

    task automatic test_io_write();
        int w;
        exp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 1'b1, 20'h003D8, 8'h29, w);
        for (int t = 1; t <= 8; t++) begin
            want = exp_ctl(t, 5, 1'b1, 1'b1);
            vecs++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL io_write_ctl t=%0d: ctl=%b required %b", t, obs, want);
            end
            if (t == 1 || t == 7) begin
                vecs++;
                if (bus_a !== 20'h003D8) begin
                    miscompares++;
                    $display("FAIL io_write_addr t=%0d: bus_a=%h required 003d8", t, bus_a);
                end
            end
            if (t >= 1 && t <= 6) begin
                vecs++;
                if (bus_d !== 8'h29) begin
                    miscompares++;
                    $display("FAIL io_write_data t=%0d: bus_d=%h required 29", t, bus_d);
                end
            end
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                vecs++;
                if ({rsp_timeout, rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL io_write_rsp: got %h required %h", {rsp_timeout, rsp_rdata}, e);
                end
            end
            tick();
        end
    endtask

    // Generic read with optional wait-state window [rdy_lo, rdy_hi) of cycles driving bus_rdy=0.
    task automatic test_read(input string name, input logic io, input logic [19:0] a,
                             input logic [7:0] din, input logic dir, input int rdy_lo,
                             input int rdy_hi, input int se);
        int w;
        bus_din = din; bus_dir = dir;
        exp_q.push_back({1'b0, dir ? din : 8'hFF});
        issue(1'b0, io, a, 8'h00, w);
        for (int t = 1; t <= se + 3; t++) begin
            if (t == rdy_lo) bus_rdy = 1'b0;
            if (t == rdy_hi) bus_rdy = 1'b1;
            want = exp_ctl(t, se, 1'b0, io);
            vecs++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL %s_ctl t=%0d: ctl=%b required %b", name, t, obs, want);
            end
            if (t == 1) begin
                vecs++;
                if (bus_a !== (io ? {4'h0, a[15:0]} : a)) begin
                    miscompares++;
                    $display("FAIL %s_addr: bus_a=%h required %h", name, bus_a, a);
                end
            end
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                vecs++;
                if ({rsp_timeout, rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL %s_rsp: got %h required %h", name, {rsp_timeout, rsp_rdata}, e);
                end
            end
            tick();
        end
        bus_rdy = 1'b1;
    endtask

    task automatic test_back_to_back();
        int w;
        exp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 1'b1, 20'hF03DA, 8'hA5, w);
        for (int t = 1; t <= 7; t++) begin
            want = exp_ctl(t, 5, 1'b1, 1'b1);
            vecs++;
            if (obs !== want || bus_a !== 20'h003DA) begin
                miscompares++;
                $display("FAIL b2b_first t=%0d: ctl=%b a=%h required %b 003da", t, obs, bus_a, want);
            end
            if (rsp_valid === 1'b1) void'(exp_q.pop_front());
            tick();
        end
        exp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 1'b0, 20'h12345, 8'h5A, w);
        vecs++;
        if (w !== 0) begin
            miscompares++;
            $display("FAIL b2b_accept_at_t8: waited=%0d required 0", w);
        end
        for (int t = 1; t <= 8; t++) begin
            want = exp_ctl(t, 5, 1'b1, 1'b0);
            vecs++;
            if (obs !== want || bus_a !== 20'h12345 || bus_d !== 8'h5A) begin
                miscompares++;
                $display("FAIL b2b_second t=%0d: ctl=%b a=%h d=%h required %b 12345 5a",
                         t, obs, bus_a, bus_d, want);
            end
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                vecs++;
                if ({rsp_timeout, rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL b2b_rsp: got %h required %h", {rsp_timeout, rsp_rdata}, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int w;
        int seen;
        issue(1'b1, 1'b0, 20'hA0000, 8'h77, w);
        tick(); tick();
        vecs++;
        if (obs !== exp_ctl(3, 5, 1'b1, 1'b0)) begin
            miscompares++;
            $display("FAIL midrst_t3: ctl=%b required %b", obs, exp_ctl(3, 5, 1'b1, 1'b0));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if (obs !== 8'b1111_1000) begin
            miscompares++;
            $display("FAIL midrst_abort: ctl=%b required 11111000", obs);
        end
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        vecs++;
        if (seen != 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: rsp pulses=%0d ready=%b required 0 1", seen, req_ready);
        end
    endtask

    task automatic test_timeout();
        int w;
        bus_rdy = 1'b0; bus_din = 8'h55; bus_dir = 1'b1;
`ifdef ISA_INIT_TIMEOUT_EN
        exp_q.push_back({1'b1, 8'hFF});
        issue(1'b0, 1'b0, 20'hB8001, 8'h00, w);
        for (int t = 1; t <= 16; t++) begin
            want = exp_ctl(t, 13, 1'b0, 1'b0);
            vecs++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL timeout_ctl t=%0d: ctl=%b required %b", t, obs, want);
            end
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                vecs++;
                if ({rsp_timeout, rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL timeout_rsp: got %h required %h", {rsp_timeout, rsp_rdata}, e);
                end
            end
            tick();
        end
        bus_rdy = 1'b1;
`else
        issue(1'b0, 1'b0, 20'hB8001, 8'h00, w);
        for (int t = 1; t <= 40; t++) begin
            want = exp_ctl(t, 1000, 1'b0, 1'b0);
            vecs++;
            if (obs !== want || rsp_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL nowait_limit t=%0d: ctl=%b to=%b required %b 0", t, obs, rsp_timeout, want);
            end
            tick();
        end
        reset = 1'b1;
        bus_rdy = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
`endif
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h0; req_wdata = 8'h00; bus_din = 8'h00; bus_dir = 1'b0; bus_rdy = 1'b1;
        test_reset();
        test_io_write();
        test_read("io_read", 1'b1, 20'h003DA, 8'hF9, 1'b1, 0, 0, 5);
        test_read("wait_states", 1'b0, 20'hB8000, 8'h41, 1'b1, 4, 7, 8);
        test_read("float_bus", 1'b0, 20'hC0000, 8'h3C, 1'b0, 0, 0, 5);
        test_back_to_back();
        test_mid_reset();
        test_timeout();
        vecs++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
